// File: rtl/screen_sequencer.sv
// Screen-mode sequencer: title/flash loop, black clear, play, game-over hold.
// Each show strobe is held for exactly one frame so the drawer stays frame-aligned.
module screen_sequencer #(
    parameter int PIXELS       = 19200,
    parameter int FLASH_PERIOD = 12500000,
    parameter int HOLD_CYCLES  = 100000000
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic game_over,
    output logic showTitle,
    output logic flash,
    output logic showBlack,
    output logic showGameOver,
    output logic plot,
    output logic game_enable,
    output logic draw_done
);

    // state   | meaning
    // T_DRAW  | drawing title frame
    // T_IDLE  | title shown, waiting for flash redraw
    // F_DRAW  | drawing flash frame (red suppressed)
    // F_IDLE  | flash shown, waiting for title redraw
    // B_DRAW  | clearing screen before play
    // PLAYING | game logic enabled
    // G_DRAW  | drawing game-over fill
    // G_HOLD  | game-over screen held
    typedef enum logic [2:0] {
        T_DRAW, T_IDLE, F_DRAW, F_IDLE, B_DRAW, PLAYING, G_DRAW, G_HOLD
    } state_t;

    localparam logic [14:0] PIX_LAST   = 15'(PIXELS - 1);
    localparam logic [26:0] FLASH_LAST = 27'(FLASH_PERIOD - 1);
    localparam logic [26:0] HOLD_LAST  = 27'(HOLD_CYCLES - 1);

    state_t      r_state, w_next;
    logic [14:0] r_pix_cnt;
    logic [26:0] r_timer;
    logic        r_start_q, r_start_pend, r_draw_done;
    logic        w_draw, w_idle, w_last, w_edge, w_title_phase, w_start_req, w_expire;

    assign w_draw        = (r_state == T_DRAW) || (r_state == F_DRAW) ||
                           (r_state == B_DRAW) || (r_state == G_DRAW);
    assign w_idle        = (r_state == T_IDLE) || (r_state == F_IDLE) || (r_state == G_HOLD);
    assign w_last        = w_draw && (r_pix_cnt == PIX_LAST);
    assign w_edge        = start & ~r_start_q;
    assign w_title_phase = (r_state == T_DRAW) || (r_state == T_IDLE) ||
                           (r_state == F_DRAW) || (r_state == F_IDLE);
    // A same-cycle edge counts as pending so idle-state start latency is one cycle.
    assign w_start_req   = r_start_pend | w_edge;
    assign w_expire      = (r_state == G_HOLD) ? (r_timer == HOLD_LAST) : (r_timer == FLASH_LAST);

    always_comb begin
        w_next       = r_state;
        showTitle    = 1'b0;
        flash        = 1'b0;
        showBlack    = 1'b0;
        showGameOver = 1'b0;
        plot         = 1'b0;
        game_enable  = 1'b0;
        case (r_state)
            T_DRAW: begin
                showTitle = 1'b1;
                plot      = 1'b1;
                if (w_last) w_next = w_start_req ? B_DRAW : T_IDLE;
            end
            T_IDLE: begin
                if (w_start_req)   w_next = B_DRAW;
                else if (w_expire) w_next = F_DRAW;
            end
            F_DRAW: begin
                flash = 1'b1;
                plot  = 1'b1;
                if (w_last) w_next = w_start_req ? B_DRAW : F_IDLE;
            end
            F_IDLE: begin
                if (w_start_req)   w_next = B_DRAW;
                else if (w_expire) w_next = T_DRAW;
            end
            B_DRAW: begin
                showBlack = 1'b1;
                plot      = 1'b1;
                if (w_last) w_next = PLAYING;
            end
            PLAYING: begin
                game_enable = 1'b1;
                if (game_over) w_next = G_DRAW;
            end
            G_DRAW: begin
                showGameOver = 1'b1;
                plot         = 1'b1;
                if (w_last) w_next = G_HOLD;
            end
            G_HOLD: begin
                if (w_expire) w_next = T_DRAW;
            end
            default: w_next = T_DRAW;
        endcase
    end

    assign draw_done = r_draw_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= T_DRAW;
            r_pix_cnt    <= '0;
            r_timer      <= '0;
            r_start_q    <= 1'b0;
            r_start_pend <= 1'b0;
            r_draw_done  <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_start_q   <= start;
            r_draw_done <= w_last;
            r_pix_cnt   <= (w_draw && !w_last) ? r_pix_cnt + 15'd1 : '0;
            // Timer is zero whenever an idle state is entered and counts while it is held.
            r_timer     <= (w_idle && (w_next == r_state)) ? r_timer + 27'd1 : '0;
            if (w_next == B_DRAW)
                r_start_pend <= 1'b0;
            else if (w_edge && w_title_phase)
                r_start_pend <= 1'b1;
        end
    end

endmodule

// File: tb/tb_screen_sequencer.sv
// Bench for screen_sequencer: expected output vectors are queued per cycle as
// stimulus is driven and compared at the following falling edge.
module tb_screen_sequencer;

    logic clk = 1'b0;
    logic rst, start, game_over;
    logic showTitle, flash, showBlack, showGameOver, plot, game_enable, draw_done;

    // Vector order: {showTitle, flash, showBlack, showGameOver, plot, game_enable, draw_done}
    localparam logic [6:0] V_IDLE  = 7'b0000000;
    localparam logic [6:0] V_TITLE = 7'b1000100;
    localparam logic [6:0] V_FLASH = 7'b0100100;
    localparam logic [6:0] V_BLACK = 7'b0010100;
    localparam logic [6:0] V_GO    = 7'b0001100;
    localparam logic [6:0] V_PLAY  = 7'b0000010;
    localparam logic [6:0] D       = 7'b0000001;

    logic [6:0] exp_q[$];
    int         cyc_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    logic [6:0] w_out;

    assign w_out = {showTitle, flash, showBlack, showGameOver, plot, game_enable, draw_done};

    screen_sequencer #(.PIXELS(16), .FLASH_PERIOD(8), .HOLD_CYCLES(20)) dut (
        .clk(clk), .rst(rst), .start(start), .game_over(game_over),
        .showTitle(showTitle), .flash(flash), .showBlack(showBlack),
        .showGameOver(showGameOver), .plot(plot), .game_enable(game_enable),
        .draw_done(draw_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [6:0] e;
            int         c;
            e = exp_q.pop_front();
            c = cyc_q.pop_front();
            chk($sformatf("out@cyc%0d", c), 32'(w_out), 32'(e));
        end
    end

    task automatic push(input logic [6:0] e);
        exp_q.push_back(e);
        cyc_q.push_back(cyc);
        cyc++;
    endtask

    task automatic step(input logic s, input logic g, input logic [6:0] e);
        @(posedge clk);
        #1;
        start     = s;
        game_over = g;
        push(e);
    endtask

    task automatic rep(input int n, input logic s, input logic g, input logic [6:0] e);
        for (int i = 0; i < n; i++) step(s, g, e);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; game_over = 1'b0;
        #2;
        chk("reset_outputs", 32'(w_out), 32'(V_TITLE));

        // Free-running title/flash loop
        @(posedge clk); #1; rst = 1'b0; push(V_TITLE);
        rep(15, 0, 0, V_TITLE);
        step(0, 0, V_IDLE | D);  rep(7, 0, 0, V_IDLE);
        step(0, 0, V_FLASH);     rep(15, 0, 0, V_FLASH);
        step(0, 0, V_IDLE | D);  rep(7, 0, 0, V_IDLE);
        step(0, 0, V_TITLE);     rep(15, 0, 0, V_TITLE);

        // Start edge on third T_IDLE cycle
        step(0, 0, V_IDLE | D);  step(0, 0, V_IDLE);  step(1, 0, V_IDLE);
        step(1, 0, V_BLACK);     rep(15, 1, 0, V_BLACK);

        // PLAYING: game_over together with a start edge
        step(1, 0, V_PLAY | D);  step(0, 0, V_PLAY);  step(1, 1, V_PLAY);
        step(0, 0, V_GO);        rep(15, 0, 0, V_GO);

        // G_HOLD for 20 cycles, start edge ignored
        step(0, 0, V_IDLE | D);  rep(4, 0, 0, V_IDLE);
        step(1, 0, V_IDLE);      rep(13, 1, 0, V_IDLE);  step(0, 0, V_IDLE);
        step(0, 0, V_TITLE);     rep(15, 0, 0, V_TITLE);

        // game_over in T_IDLE has no effect
        step(0, 0, V_IDLE | D);  step(0, 1, V_IDLE);  rep(6, 0, 0, V_IDLE);

        // Start edge at F_DRAW cycle 5, held high afterwards
        step(0, 0, V_FLASH);     rep(3, 0, 0, V_FLASH);
        step(1, 0, V_FLASH);     rep(11, 1, 0, V_FLASH);
        step(1, 0, V_BLACK | D); rep(15, 1, 0, V_BLACK);
        step(1, 0, V_PLAY | D);  rep(5, 1, 0, V_PLAY);
        step(1, 1, V_PLAY);
        step(1, 0, V_GO);        rep(5, 1, 0, V_GO);

        // Asynchronous reset during G_DRAW cycle 7
        @(posedge clk); #1; start = 1'b0; push(V_TITLE);
        #1 rst = 1'b1;
        #1 chk("async_reset", 32'(w_out), 32'(V_TITLE));
        @(posedge clk); #1; rst = 1'b0; push(V_TITLE);
        rep(15, 0, 0, V_TITLE);
        step(0, 0, V_IDLE | D);  rep(7, 0, 0, V_IDLE);
        step(0, 0, V_FLASH);     rep(3, 0, 0, V_FLASH);

        @(negedge clk); #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/screen_sequencer.md
# screen_sequencer

Screen-mode controller directly upstream of the full-screen drawer. It generates the mutually exclusive `showTitle`, `showBlack`, `showGameOver` and `flash` strobes, each held for exactly one frame of pixel cycles, so the drawer's free-running address counter stays frame-aligned. It also sequences title → flash → play → game-over → title, and gates the game logic through `game_enable`.

## Interface
- `PIXELS`, 19200: cycles per full-screen frame (160×120).
- `FLASH_PERIOD`, 12500000: idle cycles between title and flash redraws.
- `HOLD_CYCLES`, 100000000: idle cycles the game-over screen is held.
- `clk` in 1: system clock, all state updates on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: start request, synchronous level, active-high.
- `game_over` in 1: one-cycle pulse from game logic.
- `showTitle` out 1: drawer strobe, title image.
- `flash` out 1: drawer strobe, title with red suppressed.
- `showBlack` out 1: drawer strobe, clear screen.
- `showGameOver` out 1: drawer strobe, game-over fill.
- `plot` out 1: VGA write enable, high in every draw cycle.
- `game_enable` out 1: high only in PLAYING.
- `draw_done` out 1: one-cycle pulse in the first cycle after any frame ends.

## Operation
- States:
  - T_DRAW: `showTitle`, `plot`.
  - T_IDLE: no outputs.
  - F_DRAW: `flash`, `plot`.
  - F_IDLE: no outputs.
  - B_DRAW: `showBlack`, `plot`.
  - PLAYING: `game_enable`.
  - G_DRAW: `showGameOver`, `plot`.
  - G_HOLD: no outputs.
- Outputs are a Moore decode of the state register. At most one show strobe is high in any cycle.
- Draw states:
  - `pix_cnt` (15 bits) increments every cycle.
  - The state exits when `pix_cnt == PIXELS-1`; `pix_cnt` then clears to 0.
  - A draw is never truncated.
- Transitions:
  - T_DRAW→T_IDLE.
  - T_IDLE→F_DRAW on timer expiry.
  - F_DRAW→F_IDLE.
  - F_IDLE→T_DRAW on timer expiry.
  - B_DRAW→PLAYING.
  - PLAYING→G_DRAW on `game_over`.
  - G_DRAW→G_HOLD.
  - G_HOLD→T_DRAW on timer expiry.
- Idle timer (27 bits):
  - Clears on entry to T_IDLE, F_IDLE and G_HOLD.
  - Expiry is `timer == FLASH_PERIOD-1`, or `HOLD_CYCLES-1` in G_HOLD.
- Start handling:
  - A rising edge (`start & ~start_q`) sets `start_pend` in any title-phase state (T_DRAW, T_IDLE, F_DRAW, F_IDLE).
  - When `start_pend` is set in T_IDLE or F_IDLE, or at the end of T_DRAW/F_DRAW, the next state is B_DRAW and `start_pend` clears.
  - `start_pend` beats timer expiry in the same cycle.
  - Start edges are ignored in B_DRAW, PLAYING, G_DRAW and G_HOLD, and `start_pend` is cleared on entry to B_DRAW.
- `game_over` is ignored outside PLAYING. In PLAYING it beats a simultaneous start edge.
- Reset mid-operation, asynchronous:
  - state=T_DRAW, `pix_cnt`=0, timer=0, `start_pend`=0, `start_q`=0.
  - The drawer must be reset concurrently.
- Reset output values: `showTitle`=1, `plot`=1; all other outputs 0, including `draw_done`=0.

## Timing
- Outputs change one cycle after the transition condition is sampled, since the state is registered.
- Each draw state lasts exactly `PIXELS` cycles. Consecutive frames have no gap and no overlap.
- `draw_done` rises in the first cycle of the following state.
- Start latency from idle: edge sampled at cycle n → `showBlack` high at n+1.
- Start latency from a draw: `showBlack` goes high the cycle after that draw's last pixel.
- `game_over` at cycle n in PLAYING → `game_enable` low and `showGameOver` high at n+1.
- Title/flash period = `PIXELS` + `FLASH_PERIOD` cycles per phase.

## Test plan
Bench parameters: `PIXELS`=16, `FLASH_PERIOD`=8, `HOLD_CYCLES`=20.
- Release `rst`, `start` held 0: `showTitle`/`plot` high 16 cycles, then all low 8 cycles, then `flash` 16 cycles, then 8 idle, then `showTitle` again. `draw_done` pulses after each draw.
- `start` 0→1 at the 3rd T_IDLE cycle: `showBlack` high the next cycle for 16 cycles, then `game_enable`=1 with no strobes.
- `start` edge at cycle 5 of F_DRAW: `flash` stays high all 16 cycles, then `showBlack` follows immediately. The flash frame is not truncated.
- In PLAYING, `game_over` and a `start` edge in the same cycle: `showGameOver` 16 cycles, then 20 idle cycles (start ignored), then `showTitle`.
- `game_over` pulsed in T_IDLE: no effect.
- `start` held high across the title phase: only one transition occurs.
- `rst` asserted at cycle 7 of G_DRAW: asynchronously `showTitle`=1, `showGameOver`=0, `game_enable`=0. After release, a full 16-cycle title frame follows.
